tx_mux_scheduler: RTL and testbench

//  Sequences the 4:1 two-bit transmit mux (select sB/sA, in0..in2 live, code 2'b11 = idle/zero).

---
 rtl/tx_mux_pkg.sv | 36 +++
 rtl/tx_mux_scheduler_rr_pick3.sv | 25 ++
 rtl/tx_mux_scheduler.sv | 114 +++++++++++
 tb/tb_tx_mux_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_mux_pkg.sv
// Shared types, constants and small helpers for the transmit mux scheduler.
package tx_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } state_e;

    localparam int         NUM_SRC  = 3;
    localparam logic [1:0] SEL_IDLE = 2'b11;
    localparam logic [1:0] SRC_CODE_0 = 2'b00;
    localparam logic [1:0] SRC_CODE_1 = 2'b01;
    localparam logic [1:0] SRC_CODE_2 = 2'b10;

    // Source index plus offset, wrapped modulo three (inputs never exceed 2).
    function automatic logic [1:0] src_add(input logic [1:0] a, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, k};
        s = (s >= 3'd3) ? (s - 3'd3) : s;
        return s[1:0];
    endfunction

    // Mux select code for a source; anything else parks the mux on the idle leg.
    function automatic logic [1:0] src_code(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            2'd0:    code = SRC_CODE_0;
            2'd1:    code = SRC_CODE_1;
            2'd2:    code = SRC_CODE_2;
            default: code = SEL_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tx_mux_scheduler_rr_pick3.sv
// Combinational round-robin picker over three requesters, starting at ptr.
module rr_pick3
    import tx_mux_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand_s;

    // Scan from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        found  = 1'b0;
        idx    = 2'b00;
        cand_s = 2'b00;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand_s = src_add(ptr, 2'(k));
            found  = found | req[cand_s];
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/tx_mux_scheduler.sv
// Grants one frame or burst at a time to one of three symbol sources, drives the
// 4:1 mux select and a one-hot consume strobe, and forces one idle cycle between grants.
module tx_mux_scheduler
    import tx_mux_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] req,
    input  logic [2:0] last,
    output logic       sB,
    output logic       sA,
    output logic [2:0] grant,
    output logic       out_valid,
    output logic       busy
);

    state_e           state_r, state_s;
    logic [1:0]       owner_r, owner_s;
    logic [1:0]       rr_ptr_r, rr_ptr_s;
    logic [1:0]       sel_r, sel_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             found_s;
    logic [1:0]       win_s;
    logic [2:0]       grant_s;
    logic             take_s;
    logic             release_s;

    rr_pick3 u_pick (
        .req   (req),
        .ptr   (rr_ptr_r),
        .found (found_s),
        .idx   (win_s)
    );

    // Consume strobe for the current owner and the end-of-grant decision.
    always_comb begin
        grant_s = 3'b000;
        if (state_r == SEND) begin
            grant_s[owner_r] = en & req[owner_r];
        end else begin
            grant_s = 3'b000;
        end
        take_s    = |grant_s;
        release_s = take_s & (last[owner_r] | (cnt_r == CNT_W'(BURST_MAX - 1)));
    end

    // Next-state logic: arbitrate when idle or in the gap, hold through stalls while sending.
    always_comb begin
        state_s  = state_r;
        owner_s  = owner_r;
        rr_ptr_s = rr_ptr_r;
        cnt_s    = cnt_r;
        sel_s    = sel_r;
        case (state_r)
            IDLE, GAP: begin
                if (en && found_s) begin
                    state_s = SEND;
                    owner_s = win_s;
                    sel_s   = src_code(win_s);
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                    sel_s   = SEL_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            SEND: begin
                if (release_s) begin
                    state_s  = GAP;
                    rr_ptr_s = src_add(owner_r, 2'd1);
                    sel_s    = SEL_IDLE;
                    cnt_s    = {CNT_W{1'b0}};
                end else if (take_s) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                sel_s   = SEL_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, ownership, pointer, burst counter and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            owner_r  <= 2'd0;
            rr_ptr_r <= 2'd0;
            cnt_r    <= {CNT_W{1'b0}};
            sel_r    <= SEL_IDLE;
        end else begin
            state_r  <= state_s;
            owner_r  <= owner_s;
            rr_ptr_r <= rr_ptr_s;
            cnt_r    <= cnt_s;
            sel_r    <= sel_s;
        end
    end

    assign sB        = sel_r[1];
    assign sA        = sel_r[0];
    assign grant     = grant_s;
    assign out_valid = take_s;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_tx_mux_scheduler.sv
// Self-checking bench: instance 0 uses BURST_MAX=4, instance 1 uses BURST_MAX=1.
// A transaction-level reference model predicts every output each cycle.
module tb_tx_mux_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_v    [2];
    logic [2:0] req_v   [2];
    logic [2:0] last_v  [2];
    logic       sb_v    [2];
    logic       sa_v    [2];
    logic [2:0] grant_v [2];
    logic       ov_v    [2];
    logic       busy_v  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner (-1 = nobody), symbols sent in this grant, rotation start, gap flag.
    int         own_m  [2];
    int         sent_m [2];
    int         rr_m   [2];
    bit         gap_m  [2];
    int         bm     [2] = '{4, 1};
    logic [6:0] exp_v  [2];

    always #5 clk = ~clk;

    tx_mux_scheduler #(.BURST_MAX(4), .CNT_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .req(req_v[0]), .last(last_v[0]),
        .sB(sb_v[0]), .sA(sa_v[0]), .grant(grant_v[0]), .out_valid(ov_v[0]), .busy(busy_v[0])
    );

    tx_mux_scheduler #(.BURST_MAX(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .req(req_v[1]), .last(last_v[1]),
        .sB(sb_v[1]), .sA(sa_v[1]), .grant(grant_v[1]), .out_valid(ov_v[1]), .busy(busy_v[1])
    );

    function automatic logic [6:0] obs(input int i);
        return {sb_v[i], sa_v[i], grant_v[i], ov_v[i], busy_v[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            own_m[i] = -1; sent_m[i] = 0; rr_m[i] = 0; gap_m[i] = 1'b0;
        end
    endtask

    // Expected {sel, grant, out_valid, busy} for the present model state and inputs.
    task automatic predict();
        for (int i = 0; i < 2; i++) begin
            logic [1:0] sel;
            logic [2:0] g;
            sel = 2'b11;
            g   = 3'b000;
            if (own_m[i] >= 0) begin
                sel = 2'(own_m[i]);
                if (en_v[i] && req_v[i][own_m[i]]) g[own_m[i]] = 1'b1;
            end
            exp_v[i] = {sel, g, |g, (own_m[i] >= 0) || gap_m[i]};
        end
    endtask

    // Apply one clock of the transfer rules to the model, then move to the next falling edge.
    task automatic advance();
        for (int i = 0; i < 2; i++) begin
            if (own_m[i] >= 0) begin
                if (en_v[i] && req_v[i][own_m[i]]) begin
                    sent_m[i]++;
                    if (last_v[i][own_m[i]] || sent_m[i] == bm[i]) begin
                        rr_m[i]   = (own_m[i] + 1) % 3;
                        own_m[i]  = -1;
                        gap_m[i]  = 1'b1;
                        sent_m[i] = 0;
                    end
                end
            end else begin
                gap_m[i] = 1'b0;
                if (en_v[i]) begin
                    for (int k = 0; k < 3; k++) begin
                        int s;
                        s = (rr_m[i] + k) % 3;
                        if (req_v[i][s] && own_m[i] < 0) begin
                            own_m[i]  = s;
                            sent_m[i] = 0;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en_v[i] = 1'b1; req_v[i] = 3'b000; last_v[i] = 3'b000;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [2:0] seq_exp [9] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        rst_n = 1'b0;
        en_v[0] = 1'b1; req_v[0] = 3'b111; last_v[0] = 3'b111;
        en_v[1] = 1'b1; req_v[1] = 3'b000; last_v[1] = 3'b000;
        repeat (3) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== 7'b11_000_0_0) begin
                    n_fail++;
                    $display("FAIL reset_hold inst%0d: got %b expected %b", i, obs(i), 7'b11_000_0_0);
                end
            end
        end
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 9; c++) begin
            #1;
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL reset_rr inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_v[i]);
                end
            end
            n_checks++;
            if (grant_v[0] !== seq_exp[c]) begin
                n_fail++;
                $display("FAIL reset_rr_order cyc%0d: grant %b expected %b", c, grant_v[0], seq_exp[c]);
            end
            advance();
        end
    endtask

    task automatic test_burst();
        int fs, runlen;
        int bursts[$];
        int bexp [3] = '{4, 4, 2};
        do_reset();
        req_v[0] = 3'b010;
        fs = 0; runlen = 0;
        for (int c = 0; c < 40 && fs < 10; c++) begin
            last_v[0] = (fs == 9) ? 3'b010 : 3'b000;
            #1;
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL burst inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_v[i]);
                end
            end
            if (grant_v[0][1] === 1'b1) runlen++;
            else if (runlen > 0) begin bursts.push_back(runlen); runlen = 0; end
            if (exp_v[0][3]) fs++;
            advance();
        end
        if (runlen > 0) bursts.push_back(runlen);
        req_v[0] = 3'b000; last_v[0] = 3'b000;
        n_checks++;
        if (bursts.size() != 3) begin
            n_fail++;
            $display("FAIL burst_count: got %0d bursts expected 3", bursts.size());
        end else begin
            for (int b = 0; b < 3; b++) begin
                n_checks++;
                if (bursts[b] != bexp[b]) begin
                    n_fail++;
                    $display("FAIL burst_len%0d: got %0d expected %0d", b, bursts[b], bexp[b]);
                end
            end
        end
        advance();
    endtask

    task automatic test_stall();
        do_reset();
        last_v[0] = 3'b000;
        for (int c = 0; c < 14; c++) begin
            req_v[0] = (c >= 3 && c < 6) ? 3'b000 : 3'b001;
            en_v[0]  = (c >= 7 && c < 10) ? 1'b0 : 1'b1;
            #1;
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL stall inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_v[i]);
                end
            end
            if ((c >= 3 && c < 6) || (c >= 7 && c < 10)) begin
                n_checks++;
                if ({sb_v[0], sa_v[0], grant_v[0]} !== 5'b00_000) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc%0d: sel/grant %b expected 00000", c, {sb_v[0], sa_v[0], grant_v[0]});
                end
            end
            if (c == 11) begin
                n_checks++;
                if ({sb_v[0], sa_v[0], grant_v[0]} !== 5'b11_000) begin
                    n_fail++;
                    $display("FAIL stall_count_gap: sel/grant %b expected 11000", {sb_v[0], sa_v[0], grant_v[0]});
                end
            end
            advance();
        end
        en_v[0] = 1'b1; req_v[0] = 3'b000;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_v[0] = 3'b001;
        for (int c = 0; c < 3; c++) begin
            #1;
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL arst_pre inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_v[i]);
                end
            end
            advance();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs(0) !== 7'b11_000_0_0) begin
            n_fail++;
            $display("FAIL arst_immediate: got %b expected %b", obs(0), 7'b11_000_0_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_v[0] = 3'b010;
        for (int c = 0; c < 3; c++) begin
            #1;
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL arst_post inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_v[i]);
                end
            end
            if (c == 1) begin
                n_checks++;
                if (grant_v[0] !== 3'b010) begin
                    n_fail++;
                    $display("FAIL arst_src1: grant %b expected 010", grant_v[0]);
                end
            end
            advance();
        end
        req_v[0] = 3'b000;
    endtask

    task automatic test_burst1();
        logic [1:0] sel_exp [8] = '{2'b11, 2'b00, 2'b11, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
        do_reset();
        req_v[1] = 3'b101;
        for (int c = 0; c < 8; c++) begin
            #1;
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL burst1 inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_v[i]);
                end
            end
            n_checks++;
            if ({sb_v[1], sa_v[1]} !== sel_exp[c]) begin
                n_fail++;
                $display("FAIL burst1_sel cyc%0d: got %b expected %b", c, {sb_v[1], sa_v[1]}, sel_exp[c]);
            end
            advance();
        end
        req_v[1] = 3'b000;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                en_v[i]   = ($urandom_range(7, 0) != 0);
                req_v[i]  = 3'($urandom_range(7, 0));
                last_v[i] = {($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0)};
            end
            #1;
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: got %b expected %b", i, c, obs(i), exp_v[i]);
                end
            end
            advance();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en_v[i] = 1'b0; req_v[i] = 3'b000; last_v[i] = 3'b000;
        end
        model_reset();
        test_reset();
        test_burst();
        test_stall();
        test_async_reset();
        test_burst1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
